// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: IDLE/SETUP/ACCESS FSM with all outputs registered.
// Optional ACCESS-phase timeout is built only when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        P_clk,
    input  logic        P_rst_n,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_write,
    input  logic [63:0] rq_addr,
    input  logic [63:0] rq_wdata,
    output logic [1:0]  rq_grant,
    output logic [1:0]  rq_done,
    output logic [31:0] rq_rdata,
    output logic        rq_err,
    output logic [31:0] P_addr,
    output logic [31:0] P_wdata,
    output logic        P_selx,
    output logic        P_enable,
    output logic        P_write,
    input  logic        P_ready,
    input  logic        P_slverr,
    input  logic [31:0] P_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        selx_q, selx_d;
    logic        enable_q, enable_d;
    logic        write_q, write_d;
    logic        cur_q, cur_d;
    logic        last_q, last_d;

    logic [1:0]  elig;
    logic        any_elig;
    logic        win;
    logic        timeout;
    logic        finish;

    // A requester completing this cycle still has valid high; mask it out.
    assign elig     = rq_valid & ~done_q;
    assign any_elig = |elig;
    assign win      = (elig == 2'b11) ? ~last_q : elig[1];

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Fires in the ACCESS cycle whose stall brings the count to TIMEOUT_CYCLES.
    assign timeout = (state_q == StAccess) && !P_ready && (cnt_q == TimeoutLast);

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == StSetup) begin
            cnt_d = 8'd0;
        end else if (state_q == StAccess && !P_ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign finish = (state_q == StAccess) && (P_ready || timeout);

    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (any_elig) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (finish) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d  = 2'b00;
        done_d   = 2'b00;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        cur_d    = cur_q;
        last_d   = last_q;
        selx_d   = (state_d != StIdle);
        enable_d = (state_d == StAccess);

        if (state_q == StIdle && any_elig) begin
            grant_d[win] = 1'b1;
            addr_d       = win ? rq_addr[63:32] : rq_addr[31:0];
            wdata_d      = win ? rq_wdata[63:32] : rq_wdata[31:0];
            write_d      = rq_write[win];
            cur_d        = win;
        end

        if (finish) begin
            done_d[cur_q] = 1'b1;
            last_d        = cur_q;
            // P_ready low here means the transfer was cut off by the timeout.
            err_d         = P_ready ? P_slverr : 1'b1;
            rdata_d       = (P_ready && !write_q) ? P_rdata : 32'd0;
        end
    end

    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            selx_q   <= 1'b0;
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            cur_q    <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            grant_q  <= grant_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            selx_q   <= selx_d;
            enable_q <= enable_d;
            write_q  <= write_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
        end
    end

    assign rq_grant = grant_q;
    assign rq_done  = done_q;
    assign rq_rdata = rdata_q;
    assign rq_err   = err_q;
    assign P_addr   = addr_q;
    assign P_wdata  = wdata_q;
    assign P_selx   = selx_q;
    assign P_enable = enable_q;
    assign P_write  = write_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: table of single transfers plus contention,
// reset-mid-ACCESS and timeout sequences (timeout checks follow APB_ARB_TIMEOUT_EN).
module tb_apb_master_arb;

    logic        P_clk;
    logic        P_rst_n;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_write;
    logic [63:0] rq_addr;
    logic [63:0] rq_wdata;
    logic [1:0]  rq_grant;
    logic [1:0]  rq_done;
    logic [31:0] rq_rdata;
    logic        rq_err;
    logic [31:0] P_addr;
    logic [31:0] P_wdata;
    logic        P_selx;
    logic        P_enable;
    logic        P_write;
    logic        P_ready;
    logic        P_slverr;
    logic [31:0] P_rdata;

    logic        auto_rd;
    logic [31:0] rdata_drv;
    localparam logic [31:0] RdKey = 32'h5A5A_0000;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          req;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    apb_master_arb #(.TIMEOUT_CYCLES(4)) dut (
        .P_clk    (P_clk),
        .P_rst_n  (P_rst_n),
        .rq_valid (rq_valid),
        .rq_write (rq_write),
        .rq_addr  (rq_addr),
        .rq_wdata (rq_wdata),
        .rq_grant (rq_grant),
        .rq_done  (rq_done),
        .rq_rdata (rq_rdata),
        .rq_err   (rq_err),
        .P_addr   (P_addr),
        .P_wdata  (P_wdata),
        .P_selx   (P_selx),
        .P_enable (P_enable),
        .P_write  (P_write),
        .P_ready  (P_ready),
        .P_slverr (P_slverr),
        .P_rdata  (P_rdata)
    );

    initial P_clk = 1'b0;
    always #5 P_clk = ~P_clk;

    // Completer read data: either a fixed value or derived from the address.
    always_comb P_rdata = auto_rd ? (P_addr ^ RdKey) : rdata_drv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge P_clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string name);
        chk({name, "_selx"},   P_selx,   1'b0);
        chk({name, "_enable"}, P_enable, 1'b0);
        chk({name, "_grant"},  rq_grant, 2'b00);
        chk({name, "_done"},   rq_done,  2'b00);
        chk({name, "_rdata"},  rq_rdata, 32'd0);
        chk({name, "_err"},    rq_err,   1'b0);
        chk({name, "_addr"},   P_addr,   32'd0);
        chk({name, "_wdata"},  P_wdata,  32'd0);
        chk({name, "_write"},  P_write,  1'b0);
    endtask

    // Runs one transfer from IDLE; entered and left at posedge+1.
    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        oh = 2'b01 << v.req;
        rq_valid = oh;
        rq_write = v.write ? oh : 2'b00;
        rq_addr[v.req*32 +: 32]  = v.addr;
        rq_wdata[v.req*32 +: 32] = v.wdata;
        P_ready   = 1'b0;
        P_slverr  = v.slverr;
        rdata_drv = v.prdata;
        @(negedge P_clk);
        chk("v_c0_grant", rq_grant, 2'b00);
        chk("v_c0_selx", P_selx, 1'b0);
        step();
        @(negedge P_clk);
        chk("v_setup_grant", rq_grant, oh);
        chk("v_setup_selx", P_selx, 1'b1);
        chk("v_setup_enable", P_enable, 1'b0);
        chk("v_setup_addr", P_addr, v.addr);
        chk("v_setup_wdata", P_wdata, v.wdata);
        chk("v_setup_write", P_write, v.write);
        for (int c = 0; c <= v.waits; c++) begin
            step();
            P_ready = (c == v.waits);
            @(negedge P_clk);
            chk("v_acc_selx", P_selx, 1'b1);
            chk("v_acc_enable", P_enable, 1'b1);
            chk("v_acc_addr", P_addr, v.addr);
            chk("v_acc_grant", rq_grant, 2'b00);
            chk("v_acc_done", rq_done, 2'b00);
        end
        step();
        P_ready  = 1'b0;
        rq_valid = 2'b00;
        @(negedge P_clk);
        chk("v_done", rq_done, oh);
        chk("v_rdata", rq_rdata, v.exp_rdata);
        chk("v_err", rq_err, v.exp_err);
        chk("v_done_selx", P_selx, 1'b0);
        chk("v_done_enable", P_enable, 1'b0);
        step();
        @(negedge P_clk);
        chk("v_post_done", rq_done, 2'b00);
        chk("v_post_rdata", rq_rdata, 32'd0);
        chk("v_post_err", rq_err, 1'b0);
        chk("v_post_grant", rq_grant, 2'b00);
        step();
    endtask

    initial begin
        int          rem[2];
        int          ndone;
        int          gorder[$];
        int          exp_order[4];
        logic [31:0] cur_addr[2];
        logic        upd[2];
        int          seen;

        vecs[0] = '{req: 0, write: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF,
                    prdata: 32'hFFFF_0000, waits: 0, slverr: 1'b0,
                    exp_rdata: 32'd0, exp_err: 1'b0};
        vecs[1] = '{req: 1, write: 1'b0, addr: 32'h2000_0004, wdata: 32'h1111_1111,
                    prdata: 32'h1234_5678, waits: 0, slverr: 1'b0,
                    exp_rdata: 32'h1234_5678, exp_err: 1'b0};
        vecs[2] = '{req: 0, write: 1'b0, addr: 32'h0000_0040, wdata: 32'h0,
                    prdata: 32'hCAFE_F00D, waits: 3, slverr: 1'b1,
                    exp_rdata: 32'hCAFE_F00D, exp_err: 1'b1};
        vecs[3] = '{req: 1, write: 1'b1, addr: 32'h2000_0100, wdata: 32'h0BAD_F00D,
                    prdata: 32'h8888_8888, waits: 1, slverr: 1'b1,
                    exp_rdata: 32'd0, exp_err: 1'b1};
        vecs[4] = '{req: 0, write: 1'b0, addr: 32'h0000_0080, wdata: 32'h0,
                    prdata: 32'hA5A5_A5A5, waits: 2, slverr: 1'b0,
                    exp_rdata: 32'hA5A5_A5A5, exp_err: 1'b0};

        P_rst_n   = 1'b0;
        rq_valid  = 2'b00;
        rq_write  = 2'b00;
        rq_addr   = 64'd0;
        rq_wdata  = 64'd0;
        P_ready   = 1'b0;
        P_slverr  = 1'b0;
        auto_rd   = 1'b0;
        rdata_drv = 32'd0;

        #2;
        chk_idle_outs("reset");
        step();
        P_rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during ACCESS wait states; last served is requester 0 at this point.
        rq_valid = 2'b10;
        rq_write = 2'b00;
        rq_addr[63:32] = 32'h0000_0300;
        P_ready = 1'b0;
        step();
        step();
        step();
        @(negedge P_clk);
        chk("rst_pre_enable", P_enable, 1'b1);
        #2;
        P_rst_n = 1'b0;
        #1;
        chk_idle_outs("rst_async");
        step();
        chk("rst_hold_selx", P_selx, 1'b0);
        P_rst_n  = 1'b1;

        // Contention straight after release: both requesters, two reads each.
        auto_rd     = 1'b1;
        P_ready     = 1'b1;
        P_slverr    = 1'b0;
        rem[0]      = 2;
        rem[1]      = 2;
        cur_addr[0] = 32'h0000_0100;
        cur_addr[1] = 32'h0000_0200;
        rq_addr     = {cur_addr[1], cur_addr[0]};
        rq_write    = 2'b00;
        rq_valid    = 2'b11;
        ndone       = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            upd[0] = 1'b0;
            upd[1] = 1'b0;
            @(negedge P_clk);
            if (rq_grant != 2'b00) gorder.push_back(rq_grant[1] ? 1 : 0);
            if (rq_done != 2'b00) begin
                int k;
                k = rq_done[1] ? 1 : 0;
                chk("cont_rdata", rq_rdata, cur_addr[k] ^ RdKey);
                chk("cont_err", rq_err, 1'b0);
                rem[k]--;
                upd[k] = 1'b1;
                ndone++;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                if (upd[k]) begin
                    if (rem[k] <= 0) begin
                        rq_valid[k] = 1'b0;
                    end else begin
                        cur_addr[k] = cur_addr[k] + 32'd4;
                        rq_addr[k*32 +: 32] = cur_addr[k];
                    end
                end
            end
        end
        chk("cont_ndone", ndone, 4);
        chk("cont_ngrant", gorder.size(), 4);
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < gorder.size() && i < 4; i++) begin
            chk("cont_order", gorder[i], exp_order[i]);
        end

        // Completer never ready.
        auto_rd   = 1'b0;
        P_ready   = 1'b0;
        rdata_drv = 32'h7777_7777;
        rq_write  = 2'b00;
        rq_addr[31:0] = 32'h0000_0400;
        rq_valid  = 2'b01;
        step();
        rq_valid  = 2'b00;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge P_clk);
            chk("to_acc_enable", P_enable, 1'b1);
            chk("to_acc_done", rq_done, 2'b00);
        end
        step();
        @(negedge P_clk);
`ifdef APB_ARB_TIMEOUT_EN
        chk("to_done", rq_done, 2'b01);
        chk("to_err", rq_err, 1'b1);
        chk("to_rdata", rq_rdata, 32'd0);
        chk("to_selx", P_selx, 1'b0);
        chk("to_enable", P_enable, 1'b0);
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (rq_done != 2'b00) seen++;
            step();
            @(negedge P_clk);
        end
        chk("no_to_done", seen, 0);
        chk("no_to_enable", P_enable, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
